pmu_core_param: RTL and testbench
=================================

// Module: pmu_core_param
// PURPOSE
//  Parametrised PMU core: N_COUNTERS event counters with a flat address/data register port,
//  a sticky overflow vector with mask and interrupt, and an optional sequential quota monitor.
//  Sits between a bus wrapper (AXI/AHB) and SoC event lines; the wrapper only forwards reg accesses.
// PARAMETERS
//  REG_WIDTH   32  register/data bus width, >= 8
//  CNT_WIDTH   32  counter width, <= REG_WIDTH (zero-extended on read)
//  N_COUNTERS  9   number of counters/events, 1..REG_WIDTH
//  ADDR_WIDTH  5   register index width; 2^ADDR_WIDTH >= N_COUNTERS+6
// PORTS
//  clk_i        in   1           clock
//  rstn_i       in   1           asynchronous, active-low reset
//  wr_en_i      in   1           register write strobe, one write per cycle
//  addr_i       in   ADDR_WIDTH  register index for write and read
//  wdata_i      in   REG_WIDTH   write data
//  rdata_o      out  REG_WIDTH   read data, combinational from addr_i
//  events_i     in   N_COUNTERS  event pulses, sampled each cycle
//  intr_overflow_o out 1         registered |(ovf_vect & ovf_mask)
//  intr_quota_o out  1           registered sticky quota-exceeded flag (0 if QUOTA off)
// BEHAVIOUR
//  Map: 0 CFG (bit0 en, bit1 softrst, rest RAZ/WI); 1..N counters; N+1 OVF_MASK; N+2 OVF_VECT
//   (RO, write-1-to-clear); N+3 QUOTA_MASK; N+4 QUOTA_LIMIT; N+5 QUOTA_SUM (RO). Unmapped: read 0.
//  Reset: all registers, counters, vect, FSM = 0/IDLE; both interrupts 0.
//  softrst: self-clearing. A write with bit1=1 clears counters, OVF_VECT, QUOTA_SUM, intr_quota_o
//   and returns FSM to IDLE on that edge; stored bit1 reads 0; bit0 is taken from the same write.
//  Counter i: if en & events_i[i], cnt <= cnt+1 next edge. A bus write to counter i in the same
//   cycle wins (the event is dropped). Write data is truncated to CNT_WIDTH.
//  Overflow: at all-ones, an event wraps cnt to 0 and sets OVF_VECT[i] on the same edge.
//   A set and a W1C on the same bit in one cycle: set wins. Bits stay set when en=0.
//  intr_overflow_o: 1-cycle latency from the vect/mask change; held while the masked bit stays set.
//  en=0: counters hold. Writes remain possible.
// CONFIGURATION
//  PMU_QUOTA_EN defined: quota monitor built. FSM IDLE->ACC->CMP->IDLE.
//   IDLE: leaves for ACC when en=1; clears acc and idx=0.
//   ACC: one counter per cycle, acc += QUOTA_MASK[idx] ? cnt[idx] : 0, idx++.
//    After idx=N-1 it moves to CMP (N cycles).
//    acc width CNT_WIDTH+$clog2(N_COUNTERS)+1, so it never wraps.
//   CMP: QUOTA_SUM <= acc (truncated to REG_WIDTH). If acc > QUOTA_LIMIT, set intr_quota_o (sticky).
//    Returns to IDLE. Each full evaluation takes N+2 cycles and restarts while en=1.
//   Counters keep counting during ACC; sampled values are those at each visit.
//   Writing QUOTA_LIMIT or QUOTA_MASK clears intr_quota_o and sends the FSM to IDLE.
//   en=0 mid-pass: the FSM finishes the current pass, then stays IDLE.
//  PMU_QUOTA_EN undefined: no FSM or accumulator; QUOTA_* read 0 and ignore writes;
//   intr_quota_o tied 0.
// TESTING
//  T1 reset: rstn_i=0 mid-count -> all reads 0, both intr 0 asynchronously; no counting until en.
//  T2 count/priority: en=1, events_i[2] high 10 cycles -> cnt2=10; event and write 0x55 together
//     -> cnt2=0x55.
//  T3 overflow: write cnt0=all-ones, mask bit0=1, one event -> cnt0=0, vect bit0=1, intr_ovf 1 next
//     cycle; W1C bit0 -> intr 0 after 1 cycle; W1C same cycle as new wrap -> bit stays 1.
//  T4 softrst: counters nonzero, vect=0x3, write CFG=0x3 -> counters 0, vect 0, CFG reads 0x1,
//     counting resumes next cycle.
//  T5 quota (PMU_QUOTA_EN): N=4, mask=0b0101, cnt0=100, cnt2=50, events idle, limit=149
//     -> QUOTA_SUM=150 and intr_quota_o=1 within N+2 cycles; write limit=200 -> intr 0, stays 0.
//  T6 build without PMU_QUOTA_EN: QUOTA_* read 0 after writes; intr_quota_o never 1; T1-T4 pass.

Source files
------------

// File: rtl/pmu_core_param.sv
// pmu_core_param: parametrised performance-monitor core.
// N_COUNTERS event counters behind a flat address/data register port, a sticky
// overflow vector with mask and interrupt, and an optional quota monitor.
// Build option: define PMU_QUOTA_EN to build the quota monitor; without it the
// QUOTA_* registers read 0, ignore writes and intr_quota_o is tied low.
// Register map: 0 CFG, 1..N counters, N+1 OVF_MASK, N+2 OVF_VECT (W1C),
// N+3 QUOTA_MASK, N+4 QUOTA_LIMIT, N+5 QUOTA_SUM (RO); unmapped reads 0.
module pmu_core_param #(
  parameter int REG_WIDTH  = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int N_COUNTERS = 9,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [REG_WIDTH-1:0]  wdata_i,
  output logic [REG_WIDTH-1:0]  rdata_o,
  input  logic [N_COUNTERS-1:0] events_i,
  output logic                  intr_overflow_o,
  output logic                  intr_quota_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_CFG      = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_OVF_MASK = ADDR_WIDTH'(N_COUNTERS + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OVF_VECT = ADDR_WIDTH'(N_COUNTERS + 2);

  logic                  cfg_en_q;
  logic [CNT_WIDTH-1:0]  cnt_q [N_COUNTERS];
  logic [N_COUNTERS-1:0] ovf_mask_q;
  logic [N_COUNTERS-1:0] ovf_vect_q;
  logic                  intr_overflow_q;

  logic                  softrst;
  logic                  cfg_wr;
  logic [N_COUNTERS-1:0] cnt_wr;
  logic [N_COUNTERS-1:0] cnt_inc;
  logic [N_COUNTERS-1:0] cnt_wrap;
  logic [N_COUNTERS-1:0] vect_w1c;

  // Register-write decode and per-counter increment/wrap qualification.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    cfg_wr   = wr_en_i && (addr_i == ADDR_CFG);
    softrst  = cfg_wr && wdata_i[1];
    vect_w1c = (wr_en_i && (addr_i == ADDR_OVF_VECT)) ? wdata_i[N_COUNTERS-1:0] : '0;
    cnt_wr   = '0;
    cnt_inc  = '0;
    cnt_wrap = '0;
    for (int i = 0; i < N_COUNTERS; i++) begin
      cnt_wr[i]   = wr_en_i && (addr_i == ADDR_WIDTH'(i + 1));
      // A bus write to the same counter wins; the event is dropped.
      cnt_inc[i]  = cfg_en_q && events_i[i] && !cnt_wr[i];
      cnt_wrap[i] = cnt_inc[i] && (&cnt_q[i]);
    end
  end

  // CFG enable bit; the softrst bit is an action and is never stored.
  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) cfg_en_q <= 1'b0;
    else if (cfg_wr) cfg_en_q <= wdata_i[0];
  end

  // Event counters: softrst, then bus write, then increment (wraps to 0).
  // NOTE: the counter array is software-visible, so it is reset like any register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < N_COUNTERS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_COUNTERS; i++) begin
        if (softrst)         cnt_q[i] <= '0;
        else if (cnt_wr[i])  cnt_q[i] <= wdata_i[CNT_WIDTH-1:0];
        else if (cnt_inc[i]) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  // Overflow mask register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) ovf_mask_q <= '0;
    else if (wr_en_i && (addr_i == ADDR_OVF_MASK)) ovf_mask_q <= wdata_i[N_COUNTERS-1:0];
  end

  // Sticky overflow vector: a wrap on the same edge as a W1C keeps the bit set.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)      ovf_vect_q <= '0;
    else if (softrst) ovf_vect_q <= '0;
    else              ovf_vect_q <= (ovf_vect_q & ~vect_w1c) | cnt_wrap;
  end

  // Overflow interrupt, one cycle behind the vector/mask.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) intr_overflow_q <= 1'b0;
    else         intr_overflow_q <= |(ovf_vect_q & ovf_mask_q);
  end

  assign intr_overflow_o = intr_overflow_q;

`ifdef PMU_QUOTA_EN
  localparam logic [ADDR_WIDTH-1:0] ADDR_QUOTA_MASK  = ADDR_WIDTH'(N_COUNTERS + 3);
  localparam logic [ADDR_WIDTH-1:0] ADDR_QUOTA_LIMIT = ADDR_WIDTH'(N_COUNTERS + 4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_QUOTA_SUM   = ADDR_WIDTH'(N_COUNTERS + 5);
  localparam int IDX_WIDTH = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1;
  // Wide enough to sum every counter at all-ones without wrapping.
  localparam int ACC_WIDTH = CNT_WIDTH + $clog2(N_COUNTERS) + 1;
  localparam int CMP_WIDTH = (ACC_WIDTH > REG_WIDTH) ? ACC_WIDTH : REG_WIDTH;

  typedef enum logic [1:0] {Q_IDLE, Q_ACC, Q_CMP} q_state_e;

  q_state_e              q_state;
  logic [N_COUNTERS-1:0] quota_mask_q;
  logic [REG_WIDTH-1:0]  quota_limit_q;
  logic [REG_WIDTH-1:0]  quota_sum_q;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic                  intr_quota_q;

  logic                  quota_cfg_wr;
  logic [CNT_WIDTH-1:0]  sel_cnt;
  logic                  sel_mask;
  logic [CMP_WIDTH-1:0]  acc_ext;
  logic [CMP_WIDTH-1:0]  limit_ext;

  // Pick the counter under the scan index and widen operands for the compare.
  always_comb begin
    quota_cfg_wr = wr_en_i && ((addr_i == ADDR_QUOTA_MASK) || (addr_i == ADDR_QUOTA_LIMIT));
    sel_cnt      = '0;
    sel_mask     = 1'b0;
    for (int i = 0; i < N_COUNTERS; i++) begin
      if (idx_q == IDX_WIDTH'(i)) begin
        sel_cnt  = cnt_q[i];
        sel_mask = quota_mask_q[i];
      end
    end
    acc_ext   = CMP_WIDTH'(acc_q);
    limit_ext = CMP_WIDTH'(quota_limit_q);
  end

  // Quota mask and limit registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      quota_mask_q  <= '0;
      quota_limit_q <= '0;
    end else if (wr_en_i && (addr_i == ADDR_QUOTA_MASK)) begin
      quota_mask_q  <= wdata_i[N_COUNTERS-1:0];
    end else if (wr_en_i && (addr_i == ADDR_QUOTA_LIMIT)) begin
      quota_limit_q <= wdata_i;
    end
  end

  // Quota scan: IDLE -> ACC (one counter per cycle) -> CMP -> IDLE, N+2 cycles per pass.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      q_state      <= Q_IDLE;
      acc_q        <= '0;
      idx_q        <= '0;
      quota_sum_q  <= '0;
      intr_quota_q <= 1'b0;
    end else if (softrst || quota_cfg_wr) begin
      // Reconfiguration or softrst abandons the pass and drops the sticky flag.
      q_state      <= Q_IDLE;
      intr_quota_q <= 1'b0;
      if (softrst) quota_sum_q <= '0;
    end else begin
      case (q_state)
        Q_IDLE: begin
          if (cfg_en_q) begin
            q_state <= Q_ACC;
            acc_q   <= '0;
            idx_q   <= '0;
          end
        end
        Q_ACC: begin
          acc_q <= acc_q + (sel_mask ? ACC_WIDTH'(sel_cnt) : '0);
          if (idx_q == IDX_WIDTH'(N_COUNTERS - 1)) q_state <= Q_CMP;
          else                                     idx_q   <= idx_q + IDX_WIDTH'(1);
        end
        Q_CMP: begin
          quota_sum_q <= acc_ext[REG_WIDTH-1:0];
          if (acc_ext > limit_ext) intr_quota_q <= 1'b1;
          q_state <= Q_IDLE;
        end
        default: q_state <= Q_IDLE;
      endcase
    end
  end

  assign intr_quota_o = intr_quota_q;
`else
  assign intr_quota_o = 1'b0;
`endif

  // Combinational read mux; anything unmapped reads 0.
  always_comb begin
    rdata_o = '0;
    if (addr_i == ADDR_CFG)      rdata_o = REG_WIDTH'(cfg_en_q);
    if (addr_i == ADDR_OVF_MASK) rdata_o = REG_WIDTH'(ovf_mask_q);
    if (addr_i == ADDR_OVF_VECT) rdata_o = REG_WIDTH'(ovf_vect_q);
    for (int i = 0; i < N_COUNTERS; i++) begin
      if (addr_i == ADDR_WIDTH'(i + 1)) rdata_o = REG_WIDTH'(cnt_q[i]);
    end
`ifdef PMU_QUOTA_EN
    if (addr_i == ADDR_QUOTA_MASK)  rdata_o = REG_WIDTH'(quota_mask_q);
    if (addr_i == ADDR_QUOTA_LIMIT) rdata_o = quota_limit_q;
    if (addr_i == ADDR_QUOTA_SUM)   rdata_o = quota_sum_q;
`endif
  end

endmodule

// File: tb/tb_pmu_core_param.sv
// tb_pmu_core_param: directed self-checking bench for pmu_core_param.
// Built with N_COUNTERS=4, CNT_WIDTH=16 so the quota scenario and counter
// truncation are exercised. Expectations for QUOTA_* follow PMU_QUOTA_EN.
// Map here: 0 CFG, 1..4 cnt0..cnt3, 5 OVF_MASK, 6 OVF_VECT, 7 QMASK, 8 QLIMIT, 9 QSUM.
module tb_pmu_core_param;

  localparam int RW = 32;
  localparam int CW = 16;
  localparam int N  = 4;
  localparam int AW = 5;

  logic          clk;
  logic          rstn;
  logic          wr_en;
  logic [AW-1:0] addr;
  logic [RW-1:0] wdata;
  logic [RW-1:0] rdata;
  logic [N-1:0]  events;
  logic          intr_ovf;
  logic          intr_quota;

  int            n_pass;
  int            n_total;
  logic [RW-1:0] got;

  pmu_core_param #(
    .REG_WIDTH (RW),
    .CNT_WIDTH (CW),
    .N_COUNTERS(N),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .wr_en_i        (wr_en),
    .addr_i         (addr),
    .wdata_i        (wdata),
    .rdata_o        (rdata),
    .events_i       (events),
    .intr_overflow_o(intr_ovf),
    .intr_quota_o   (intr_quota)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Register write: inputs change on the falling edge, the rising edge captures.
  task automatic wr(input logic [AW-1:0] a, input logic [RW-1:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Combinational read, sampled mid-cycle.
  task automatic rd(input logic [AW-1:0] a, output logic [RW-1:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [AW-1:0] a;
    #2;
    n_total++; if (intr_ovf !== 1'b0) $display("FAIL rst_intr_ovf: got %b expected 0", intr_ovf); else n_pass++;
    n_total++; if (intr_quota !== 1'b0) $display("FAIL rst_intr_quota: got %b expected 0", intr_quota); else n_pass++;
    for (int i = 0; i < 11; i++) begin
      a = (i < 10) ? AW'(i) : AW'(31);
      rd(a, got);
      n_total++; if (got !== 32'h0) $display("FAIL rst_read[%0d]: got 0x%0h expected 0x0", a, got); else n_pass++;
    end
    @(negedge clk);
    rstn   = 1'b1;
    events = '1;
    repeat (5) @(negedge clk);
    events = '0;
    for (int i = 1; i <= N; i++) begin
      rd(AW'(i), got);
      n_total++; if (got !== 32'h0) $display("FAIL no_count_when_disabled[%0d]: got 0x%0h expected 0x0", i, got); else n_pass++;
    end
  endtask

  task automatic test_count();
    wr(0, 32'h1);
    @(negedge clk);
    events = 4'b0100;
    repeat (10) @(negedge clk);
    events = '0;
    rd(3, got);
    n_total++; if (got !== 32'd10) $display("FAIL cnt2_count: got %0d expected 10", got); else n_pass++;
    rd(1, got);
    n_total++; if (got !== 32'd0) $display("FAIL cnt0_idle: got %0d expected 0", got); else n_pass++;
    rd(0, got);
    n_total++; if (got !== 32'h1) $display("FAIL cfg_read: got 0x%0h expected 0x1", got); else n_pass++;
    // Event and bus write on the same counter in the same cycle: write wins.
    @(negedge clk);
    events = 4'b0100;
    wr_en  = 1'b1;
    addr   = 3;
    wdata  = 32'h55;
    @(negedge clk);
    wr_en  = 1'b0;
    events = '0;
    rd(3, got);
    n_total++; if (got !== 32'h55) $display("FAIL cnt2_write_priority: got 0x%0h expected 0x55", got); else n_pass++;
    wr(2, 32'h0001_2345);
    rd(2, got);
    n_total++; if (got !== 32'h2345) $display("FAIL cnt1_truncate: got 0x%0h expected 0x2345", got); else n_pass++;
    wr(2, 32'h0);
  endtask

  task automatic test_overflow();
    wr(1, 32'hFFFF);
    wr(5, 32'h1);
    n_total++; if (intr_ovf !== 1'b0) $display("FAIL ovf_intr_before: got %b expected 0", intr_ovf); else n_pass++;
    @(negedge clk);
    events = 4'b0001;
    @(negedge clk);
    events = '0;
    n_total++; if (intr_ovf !== 1'b0) $display("FAIL ovf_intr_latency: got %b expected 0", intr_ovf); else n_pass++;
    rd(1, got);
    n_total++; if (got !== 32'h0) $display("FAIL cnt0_wrap: got 0x%0h expected 0x0", got); else n_pass++;
    rd(6, got);
    n_total++; if (got !== 32'h1) $display("FAIL vect_set: got 0x%0h expected 0x1", got); else n_pass++;
    @(negedge clk);
    n_total++; if (intr_ovf !== 1'b1) $display("FAIL ovf_intr_set: got %b expected 1", intr_ovf); else n_pass++;
    // W1C: vector clears on the write edge, interrupt follows one cycle later.
    wr(6, 32'h1);
    n_total++; if (intr_ovf !== 1'b1) $display("FAIL ovf_intr_held_on_w1c: got %b expected 1", intr_ovf); else n_pass++;
    rd(6, got);
    n_total++; if (got !== 32'h0) $display("FAIL vect_w1c: got 0x%0h expected 0x0", got); else n_pass++;
    @(negedge clk);
    n_total++; if (intr_ovf !== 1'b0) $display("FAIL ovf_intr_clear: got %b expected 0", intr_ovf); else n_pass++;
    // W1C in the same cycle as a new wrap: the set wins.
    wr(1, 32'hFFFF);
    events = 4'b0001;
    wr_en  = 1'b1;
    addr   = 6;
    wdata  = 32'h1;
    @(negedge clk);
    wr_en  = 1'b0;
    events = '0;
    rd(6, got);
    n_total++; if (got !== 32'h1) $display("FAIL vect_set_beats_w1c: got 0x%0h expected 0x1", got); else n_pass++;
    rd(1, got);
    n_total++; if (got !== 32'h0) $display("FAIL cnt0_wrap2: got 0x%0h expected 0x0", got); else n_pass++;
    wr(5, 32'h0);
    @(negedge clk);
    n_total++; if (intr_ovf !== 1'b0) $display("FAIL ovf_intr_masked: got %b expected 0", intr_ovf); else n_pass++;
    // Disable: vector bits stay, counters hold.
    wr(0, 32'h0);
    @(negedge clk);
    events = 4'b1111;
    @(negedge clk);
    events = '0;
    rd(6, got);
    n_total++; if (got !== 32'h1) $display("FAIL vect_sticky_disabled: got 0x%0h expected 0x1", got); else n_pass++;
    rd(3, got);
    n_total++; if (got !== 32'h55) $display("FAIL cnt2_hold_disabled: got 0x%0h expected 0x55", got); else n_pass++;
  endtask

  task automatic test_softrst();
    wr(0, 32'h1);
    wr(2, 32'hFFFF);
    wr(4, 32'h77);
    @(negedge clk);
    events = 4'b0010;
    @(negedge clk);
    events = '0;
    rd(6, got);
    n_total++; if (got !== 32'h3) $display("FAIL vect_pre_softrst: got 0x%0h expected 0x3", got); else n_pass++;
    // softrst with an event present on the same edge: the clear wins.
    @(negedge clk);
    wr_en  = 1'b1;
    addr   = 0;
    wdata  = 32'h3;
    events = 4'b1000;
    @(negedge clk);
    wr_en  = 1'b0;
    events = '0;
    rd(4, got);
    n_total++; if (got !== 32'h0) $display("FAIL softrst_cnt3: got 0x%0h expected 0x0", got); else n_pass++;
    rd(3, got);
    n_total++; if (got !== 32'h0) $display("FAIL softrst_cnt2: got 0x%0h expected 0x0", got); else n_pass++;
    rd(6, got);
    n_total++; if (got !== 32'h0) $display("FAIL softrst_vect: got 0x%0h expected 0x0", got); else n_pass++;
    rd(0, got);
    n_total++; if (got !== 32'h1) $display("FAIL softrst_cfg: got 0x%0h expected 0x1", got); else n_pass++;
    @(negedge clk);
    events = 4'b1000;
    @(negedge clk);
    events = '0;
    rd(4, got);
    n_total++; if (got !== 32'h1) $display("FAIL softrst_resume: got 0x%0h expected 0x1", got); else n_pass++;
  endtask

`ifdef PMU_QUOTA_EN
  task automatic test_quota();
    int   cycles;
    logic seen;
    wr(1, 32'd100);
    wr(2, 32'd0);
    wr(3, 32'd50);
    wr(4, 32'd0);
    wr(7, 32'h5);
    // Limit equal to the sum is not exceeded.
    wr(8, 32'd150);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (intr_quota !== 1'b0) seen = 1'b1;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL quota_equal_no_intr: got %b expected 0", seen); else n_pass++;
    rd(9, got);
    n_total++; if (got !== 32'd150) $display("FAIL quota_sum: got %0d expected 150", got); else n_pass++;
    wr(8, 32'd149);
    cycles = 0;
    while (intr_quota !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    n_total++; if (intr_quota !== 1'b1 || cycles > N + 2) $display("FAIL quota_intr_latency: got %0d cycles (intr %b) expected <= %0d", cycles, intr_quota, N + 2); else n_pass++;
    rd(9, got);
    n_total++; if (got !== 32'd150) $display("FAIL quota_sum_exceed: got %0d expected 150", got); else n_pass++;
    wr(8, 32'd200);
    n_total++; if (intr_quota !== 1'b0) $display("FAIL quota_intr_clear: got %b expected 0", intr_quota); else n_pass++;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (intr_quota !== 1'b0) seen = 1'b1;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL quota_intr_stays_clear: got %b expected 0", seen); else n_pass++;
    rd(7, got);
    n_total++; if (got !== 32'h5) $display("FAIL quota_mask_read: got 0x%0h expected 0x5", got); else n_pass++;
    rd(8, got);
    n_total++; if (got !== 32'd200) $display("FAIL quota_limit_read: got %0d expected 200", got); else n_pass++;
  endtask
`else
  task automatic test_quota_absent();
    logic seen;
    wr(7, 32'h5);
    wr(8, 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (intr_quota !== 1'b0) seen = 1'b1;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL noquota_intr: got %b expected 0", seen); else n_pass++;
    for (int i = 7; i <= 9; i++) begin
      rd(AW'(i), got);
      n_total++; if (got !== 32'h0) $display("FAIL noquota_read[%0d]: got 0x%0h expected 0x0", i, got); else n_pass++;
    end
  endtask
`endif

  task automatic test_async_reset();
    logic exp_quota;
`ifdef PMU_QUOTA_EN
    exp_quota = 1'b1;
`else
    exp_quota = 1'b0;
`endif
    wr(5, 32'h1);
    wr(1, 32'hFFFF);
    wr(8, 32'd0);
    @(negedge clk);
    events = 4'b0001;
    @(negedge clk);
    events = '0;
    repeat (10) @(negedge clk);
    n_total++; if (intr_ovf !== 1'b1) $display("FAIL pre_reset_intr_ovf: got %b expected 1", intr_ovf); else n_pass++;
    n_total++; if (intr_quota !== exp_quota) $display("FAIL pre_reset_intr_quota: got %b expected %b", intr_quota, exp_quota); else n_pass++;
    events = '1;
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    n_total++; if (intr_ovf !== 1'b0) $display("FAIL async_rst_intr_ovf: got %b expected 0", intr_ovf); else n_pass++;
    n_total++; if (intr_quota !== 1'b0) $display("FAIL async_rst_intr_quota: got %b expected 0", intr_quota); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      rd(AW'(i), got);
      n_total++; if (got !== 32'h0) $display("FAIL async_rst_read[%0d]: got 0x%0h expected 0x0", i, got); else n_pass++;
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    events = '0;
    for (int i = 1; i <= N; i++) begin
      rd(AW'(i), got);
      n_total++; if (got !== 32'h0) $display("FAIL post_rst_no_count[%0d]: got 0x%0h expected 0x0", i, got); else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rstn    = 1'b0;
    wr_en   = 1'b0;
    addr    = '0;
    wdata   = '0;
    events  = '0;
    test_reset();
    test_count();
    test_overflow();
    test_softrst();
`ifdef PMU_QUOTA_EN
    test_quota();
`else
    test_quota_absent();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
